// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences load / N-step shift / result handshake for an
// external 8-bit shifter datapath.
module shift_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [3:0] cmd_count,
    input  logic       cmd_fill,
    output logic [2:0] sh_mode,
    output logic [7:0] sh_in,
    output logic       sh_leftmost,
    input  logic [7:0] sh_q,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] done_cnt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DONE_W = 8;

    localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(8);
    // Mode 001 makes the shifter reload sh_in; used for both load and hold.
    localparam logic [OP_W-1:0]  MODE_LOAD = OP_W'(3'b001);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] data;
        logic              fill;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] steps;
    logic [CNT_W-1:0] sat_count;
    logic             op_legal;
    logic             accept;
    logic             retire;

    // Ops 000/001 are not shift modes; such commands skip SHIFT and flag an error.
    assign op_legal  = cmd_q.op[2] | cmd_q.op[1];
    assign sat_count = (cmd_count > MAX_STEPS) ? MAX_STEPS : cmd_count;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d     = state;
        accept      = 1'b0;
        retire      = 1'b0;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        res_valid   = 1'b0;
        res_err     = 1'b0;
        res_data    = sh_q;
        sh_mode     = MODE_LOAD;
        sh_in       = sh_q;
        sh_leftmost = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sh_in = cmd_q.data;
                if (op_legal && (steps != '0)) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                sh_mode     = cmd_q.op;
                sh_leftmost = cmd_q.fill;
                if (steps == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                res_err   = ~op_legal;
                if (res_ready) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch on accept; step down-counter runs during SHIFT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
            steps <= '0;
        end else if (accept) begin
            cmd_q <= '{op: cmd_op, data: cmd_data, fill: cmd_fill};
            steps <= sat_count;
        end else if (state == S_SHIFT) begin
            steps <= steps - CNT_W'(1);
        end
    end

    // Completed-result counter, advanced on each result handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_cnt <= '0;
        end else if (retire) begin
            done_cnt <= done_cnt + DONE_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: drives shift_sequencer with an attached shifter model
// and compares against a behavioural result/timing reference.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [3:0] cmd_count = 4'd0;
    logic       cmd_fill = 1'b0;
    logic [2:0] sh_mode;
    logic [7:0] sh_in;
    logic       sh_leftmost;
    logic [7:0] sh_q = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;
    logic       busy;
    logic [7:0] done_cnt;

    int         passed = 0;
    int         total = 0;
    int         fails = 0;
    logic [7:0] exp_done = 8'd0;

    shift_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_count   (cmd_count),
        .cmd_fill    (cmd_fill),
        .sh_mode     (sh_mode),
        .sh_in       (sh_in),
        .sh_leftmost (sh_leftmost),
        .sh_q        (sh_q),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy),
        .done_cnt    (done_cnt)
    );

    always #5 clk = ~clk;

    // External shifter datapath driven by the sequencer.
    always @(posedge clk) begin
        case (sh_mode)
            3'b001:  sh_q <= sh_in;
            3'b010:  sh_q <= {1'b0, sh_q[7:1]};
            3'b011:  sh_q <= {sh_q[6:0], 1'b0};
            3'b100:  sh_q <= {sh_q[7], sh_q[7:1]};
            3'b101:  sh_q <= {sh_leftmost, sh_q[7:1]};
            3'b110:  sh_q <= {sh_q[0], sh_q[7:1]};
            3'b111:  sh_q <= {sh_q[6:0], sh_q[7]};
            default: sh_q <= sh_q;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Expected result computed arithmetically, one step at a time.
    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] d,
                                              input int n, input logic fill);
        int r;
        r = int'(d);
        if (op < 3'd2) return d;
        for (int i = 0; i < n; i++) begin
            case (op)
                3'd2:    r = r / 2;
                3'd3:    r = (r * 2) % 256;
                3'd4:    r = r / 2 + ((r >= 128) ? 128 : 0);
                3'd5:    r = r / 2 + (fill ? 128 : 0);
                3'd6:    r = r / 2 + (r % 2) * 128;
                default: r = (r * 2) % 256 + r / 128;
            endcase
        end
        return 8'(r);
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_res_valid"}, 8'(res_valid), 8'd0);
        chk({tag, "_res_err"}, 8'(res_err), 8'd0);
        chk({tag, "_done_cnt"}, done_cnt, 8'd0);
        chk({tag, "_cmd_ready"}, 8'(cmd_ready), 8'd1);
        chk({tag, "_sh_mode"}, 8'(sh_mode), 8'd1);
        chk({tag, "_sh_in"}, sh_in, sh_q);
        chk({tag, "_sh_leftmost"}, 8'(sh_leftmost), 8'd0);
    endtask

    // Issue one command at a negedge, check every cycle, optionally abort by reset.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input logic [3:0] cnt,
                          input logic fill, input int hold, input int abort_at);
        int         n;
        logic       illegal;
        logic [7:0] expv;
        logic       in_load;
        logic       in_shift;
        logic       in_done;
        illegal = (op < 3'd2);
        n = illegal ? 0 : ((cnt > 4'd8) ? 8 : int'(cnt));
        expv = ref_result(op, d, n, fill);
        chk("idle_ready", 8'(cmd_ready), 8'd1);
        chk("idle_busy", 8'(busy), 8'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = cnt;
        cmd_fill  = fill;
        res_ready = 1'b0;
        @(posedge clk);
        for (int j = 0; j <= n + 1 + hold; j++) begin
            @(negedge clk);
            if (j == abort_at) begin
                cmd_valid = 1'b0;
                rst = 1'b0;
                #1;
                reset_checks("abort");
                return;
            end
            in_load  = (j == 0);
            in_shift = (j >= 1) && (j <= n);
            in_done  = (j >= n + 1);
            chk("busy", 8'(busy), 8'd1);
            chk("cmd_ready", 8'(cmd_ready), 8'd0);
            chk("res_valid", 8'(res_valid), 8'(in_done));
            chk("res_err", 8'(res_err), 8'(in_done & illegal));
            chk("sh_mode", 8'(sh_mode), 8'(in_shift ? op : 3'b001));
            chk("sh_leftmost", 8'(sh_leftmost), 8'(in_shift & fill));
            chk("done_cnt", done_cnt, exp_done);
            if (in_load) chk("sh_in_load", sh_in, d);
            if (in_done) begin
                chk("res_data", res_data, expv);
                chk("sh_in_hold", sh_in, sh_q);
            end
            if (in_done && (j == n + 1 + hold)) begin
                cmd_valid = 1'b0;
                res_ready = 1'b1;
            end else begin
                cmd_valid = 1'($urandom);
                cmd_op    = 3'($urandom);
                cmd_data  = 8'($urandom);
                cmd_count = 4'($urandom);
                cmd_fill  = 1'($urandom);
                res_ready = 1'b0;
            end
        end
        @(posedge clk);
        exp_done = exp_done + 8'd1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_ready", 8'(cmd_ready), 8'd1);
        chk("post_busy", 8'(busy), 8'd0);
        chk("post_valid", 8'(res_valid), 8'd0);
        chk("post_done_cnt", done_cnt, exp_done);
        chk("post_sh_in", sh_in, sh_q);
        chk("post_content", sh_q, expv);
    endtask

    // Directed scenarios, a randomized run long enough to wrap done_cnt, then abort.
    initial begin
        repeat (3) @(negedge clk);
        #1;
        reset_checks("por");
        rst = 1'b1;
        do_cmd(3'b010, 8'b1001_0110, 4'd3, 1'b0, 0, -1);
        do_cmd(3'b100, 8'b1000_0001, 4'd2, 1'b0, 0, -1);
        do_cmd(3'b111, 8'b1000_0001, 4'd8, 1'b0, 0, -1);
        do_cmd(3'b111, 8'b1000_0001, 4'd12, 1'b0, 1, -1);
        do_cmd(3'b101, 8'b0000_0000, 4'd4, 1'b1, 0, -1);
        do_cmd(3'b001, 8'b0101_1010, 4'd5, 1'b0, 0, -1);
        do_cmd(3'b000, 8'hA5, 4'd0, 1'b1, 2, -1);
        do_cmd(3'b011, 8'h3C, 4'd2, 1'b1, 3, -1);
        do_cmd(3'b110, 8'h81, 4'd0, 1'b0, 0, -1);
        do_cmd(3'b110, 8'h0F, 4'd15, 1'b0, 0, -1);
        for (int k = 0; k < 260; k++) begin
            do_cmd(3'($urandom), 8'($urandom), 4'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), -1);
        end
        do_cmd(3'b011, 8'hC3, 4'd6, 1'b1, 0, 2);
        exp_done = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks("abort_hold");
        rst = 1'b1;
        do_cmd(3'b010, 8'hF0, 4'd4, 1'b0, 1, -1);
        chk("final_done_cnt", done_cnt, 8'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
